// File: rtl/conv_pkg.sv
// Shared definitions for the convolution core: FSM states, default widths
// and the full-convolution length helper.
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int SZ_W_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // LEN = sz_x + sz_h - 1 in a 7-bit sum, truncated to the address width.
    // An empty input sequence yields an empty frame.
    function automatic logic [ADDR_W_DEF-1:0] conv_len(
        input logic [SZ_W_DEF-1:0] sz_x,
        input logic [SZ_W_DEF-1:0] sz_h
    );
        if ((sz_x == '0) || (sz_h == '0))
            conv_len = '0;
        else
            conv_len = ADDR_W_DEF'({2'b00, sz_x} + {2'b00, sz_h} - 7'd1);
    endfunction

endpackage

// File: rtl/y_i_comp.sv
// Terminal-count compare for the y write index: flags the last sample of a frame.
module y_i_comp #(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] count_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic              last_o
);

    assign last_o = (count_i == (len_i - ADDR_W'(1)));

endmodule

// File: rtl/conv_y_writer.sv
// Write side of the convolution core: accepts y[n] samples over valid/ready
// and stores them at output memory addresses 0..LEN-1, then pulses done_o.
module conv_y_writer
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SZ_W   = SZ_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [SZ_W-1:0]   sz_x_i,
    input  logic [SZ_W-1:0]   sz_h_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              busy_o,
    output logic              done_o
);

    conv_state_e       state;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] len;
    logic              last;
    logic              xfer;
    logic              zero_sz;

    // Abort wins over everything, so it also blocks a transfer in the same cycle.
    assign ready_o = (state == WRITE) && !abort_i;
    assign xfer    = valid_i && ready_o;
    assign busy_o  = (state == WRITE) || (state == DONE);
    assign done_o  = (state == DONE) && !abort_i;
    assign zero_sz = (sz_x_i == '0) || (sz_h_i == '0);

    y_i_comp #(
        .ADDR_W (ADDR_W)
    ) u_y_i_comp (
        .count_i (count),
        .len_i   (len),
        .last_o  (last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            count <= '0;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len   <= conv_len(sz_x_i, sz_h_i);
                        count <= '0;
                        state <= zero_sz ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (abort_i) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (xfer) begin
                        count <= count + ADDR_W'(1);
                        if (last)
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Memory port is registered: an accepted sample is written one cycle later,
    // and address/data hold their last value between writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            mem_we_o <= xfer;
            if (xfer) begin
                mem_addr_o <= count;
                mem_data_o <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_conv_y_writer.sv
// Self-checking bench for conv_y_writer: a scoreboard of expected (addr, data)
// writes is filled as samples are driven and drained as the memory port fires.
module tb_conv_y_writer;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [SW-1:0] sz_x_i = '0;
    logic [SW-1:0] sz_h_i = '0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          busy_o;
    logic          done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int cyc      = 0;
    int last_acc = 0;
    int start_cyc = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_w;
    logic [AW-1:0]    model_addr;

    conv_y_writer u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .sz_x_i     (sz_x_i),
        .sz_h_i     (sz_h_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard drain: every memory write must match the oldest expected entry.
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_we_o) begin
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=%h, required no write",
                         mem_addr_o, mem_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_addr_o, mem_data_o} !== exp_w) begin
                    n_fail++;
                    $display("[TB] FAIL sb_write: addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr_o, mem_data_o, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is held for one cycle; sizes are scrambled afterwards to prove they were latched.
    task automatic start_frame(input logic [SW-1:0] sx, input logic [SW-1:0] sh);
        start_i = 1'b1;
        sz_x_i  = sx;
        sz_h_i  = sh;
        tick();
        start_cyc  = cyc;
        start_i    = 1'b0;
        sz_x_i     = SW'($urandom);
        sz_h_i     = SW'($urandom);
        model_addr = '0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        valid_i = 1'b1;
        data_i  = d;
        exp_q.push_back({model_addr, d});
        model_addr = model_addr + AW'(1);
        tick();
        last_acc = cyc;
        valid_i  = 1'b0;
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        n_checks++;
        if ({ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o});
        end
        tick();
        rstn = 1'b1;
        tick();
        n_checks++;
        if ({ready_o, busy_o, done_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL idle_outputs: ready/busy/done=%b, required 000",
                     {ready_o, busy_o, done_o});
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        start_frame(5'd4, 5'd3);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL b2b_ready: ready_o=%b at sample %0d, required 1", ready_o, i);
            end
            send(DW'($urandom));
        end
        n_checks++;
        if ({ready_o, busy_o, done_o} !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL b2b_done_state: ready/busy/done=%b, required 011",
                     {ready_o, busy_o, done_o});
        end
        tick();
        tick();
        n_checks++;
        if (wr_cnt != 6 || done_cnt != 1 || done_cyc != last_acc || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_summary: writes=%0d done=%0d done_cyc=%0d left=%0d, required 6 1 %0d 0",
                     wr_cnt, done_cnt, done_cyc, exp_q.size(), last_acc);
        end
    endtask

    task automatic test_gapped();
        clear_stats();
        start_frame(5'd4, 5'd3);
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                send(DW'($urandom));
            end else begin
                valid_i = 1'b0;
                tick();
            end
            n_checks++;
            if (mem_we_o !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL gap_we: mem_we_o=%b in cycle %0d, required %b",
                         mem_we_o, i, (i % 2 == 0));
            end
        end
        tick();
        n_checks++;
        if (wr_cnt != 6 || done_cnt != 1 || done_cyc != last_acc || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL gap_summary: writes=%0d done=%0d done_cyc=%0d left=%0d, required 6 1 %0d 0",
                     wr_cnt, done_cnt, done_cyc, exp_q.size(), last_acc);
        end
    endtask

    // An empty x sequence goes straight to DONE; valid is offered but must be ignored.
    task automatic test_zero_size();
        clear_stats();
        start_frame(5'd0, 5'd5);
        valid_i = 1'b1;
        data_i  = 16'hdead;
        for (int i = 0; i < 4; i++) tick();
        valid_i = 1'b0;
        n_checks++;
        if (wr_cnt != 0 || done_cnt != 1 || done_cyc < start_cyc || done_cyc > start_cyc + 1) begin
            n_fail++;
            $display("[TB] FAIL zero_size: writes=%0d done=%0d done_cyc=%0d, required 0 1 %0d..%0d",
                     wr_cnt, done_cnt, done_cyc, start_cyc, start_cyc + 1);
        end
    endtask

    task automatic test_max_frame();
        clear_stats();
        start_frame(5'd31, 5'd31);
        for (int i = 0; i < 61; i++) send(DW'($urandom));
        tick();
        tick();
        n_checks++;
        if (wr_cnt != 61 || done_cnt != 1 || done_cyc != last_acc || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL max_summary: writes=%0d done=%0d done_cyc=%0d left=%0d, required 61 1 %0d 0",
                     wr_cnt, done_cnt, done_cyc, exp_q.size(), last_acc);
        end
        n_checks++;
        if (mem_addr_o !== AW'(60)) begin
            n_fail++;
            $display("[TB] FAIL max_last_addr: mem_addr_o=%0d, required 60", mem_addr_o);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        start_frame(5'd4, 5'd3);
        for (int i = 0; i < 3; i++) send(DW'($urandom));
        abort_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'hbeef;
        #1;
        n_checks++;
        if ({ready_o, done_o} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL abort_ready: ready/done=%b, required 00", {ready_o, done_o});
        end
        tick();
        abort_i = 1'b0;
        valid_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: busy_o=%b, required 0", busy_o);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (wr_cnt != 3 || done_cnt != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_summary: writes=%0d done=%0d left=%0d, required 3 0 0",
                     wr_cnt, done_cnt, exp_q.size());
        end
        start_frame(5'd2, 5'd2);
        for (int i = 0; i < 3; i++) send(DW'($urandom));
        tick();
        tick();
        n_checks++;
        if (wr_cnt != 6 || done_cnt != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_restart: writes=%0d done=%0d left=%0d, required 6 1 0",
                     wr_cnt, done_cnt, exp_q.size());
        end
    endtask

    // Reset lands while the second write is on the memory port; that write is lost.
    task automatic test_reset_mid();
        clear_stats();
        start_frame(5'd4, 5'd3);
        send(DW'($urandom));
        send(DW'($urandom));
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got %h, required 0",
                     {ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o});
        end
        exp_q.delete();
        tick();
        rstn = 1'b1;
        clear_stats();
        start_frame(5'd1, 5'd1);
        send(16'h1234);
        tick();
        tick();
        n_checks++;
        if (wr_cnt != 1 || done_cnt != 1 || mem_addr_o !== AW'(0) || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_restart: writes=%0d done=%0d addr=%0d left=%0d, required 1 1 0 0",
                     wr_cnt, done_cnt, mem_addr_o, exp_q.size());
        end
    endtask

    initial begin
        $display("[TB] conv_y_writer bench starting");
        test_reset();
        test_back_to_back();
        test_gapped();
        test_zero_size();
        test_max_frame();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
